// File: rtl/bounding_box_centroid_if.sv
// Pixel-stream and result bundle for bounding_box_centroid.
//   master : drives ce/de/hsync/vsync/mask, observes results and live counters
//   slave  : the centroid block; consumes the stream and produces the results
interface bounding_box_centroid_if #(
    parameter int CW    = 10,
    parameter int CNT_W = 19
);
    logic             ce, de, hsync, vsync, mask;
    logic [CW-1:0]    x_min, x_max, y_min, y_max, cx, cy, c_w, c_h;
    logic [CNT_W-1:0] pix_cnt;
    logic             box_valid, res_valid, frame_drop;

    modport master (
        output ce, de, hsync, vsync, mask,
        input  x_min, x_max, y_min, y_max, cx, cy, c_w, c_h,
        input  pix_cnt, box_valid, res_valid, frame_drop
    );

    modport slave (
        input  ce, de, hsync, vsync, mask,
        output x_min, x_max, y_min, y_max, cx, cy, c_w, c_h,
        output pix_cnt, box_valid, res_valid, frame_drop
    );
endinterface

// File: rtl/bounding_box_centroid.sv
// Per-frame bounding box and centroid of a skin-mask pixel stream.
// Ports: clk, rst (sync, active high), bus (slave modport of
// bounding_box_centroid_if): stream in (ce/de/hsync/vsync/mask), latched
// results out (box, centroid, count, box_valid), res_valid / frame_drop
// strobes, live c_w/c_h counters.
// Accumulation runs during the frame; at end of frame the accumulators are
// snapshotted and one shared restoring divider computes cx then cy while the
// next frame accumulates.
module bounding_box_centroid #(
    parameter int IMG_W   = 720,
    parameter int IMG_H   = 576,
    parameter int CW      = 10,
    parameter int BORDER  = 1,
    parameter int MIN_PIX = 64,
    parameter int CNT_W   = 19,
    parameter int ACC_W   = 30
) (
    input logic                       clk,
    input logic                       rst,
    bounding_box_centroid_if.slave    bus
);
    localparam int SW = $clog2(ACC_W);
    localparam logic [CW-1:0] W_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] H_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] X_LO   = CW'(BORDER);
    localparam logic [CW-1:0] X_HI   = CW'(IMG_W - 1 - BORDER);
    localparam logic [CW-1:0] Y_LO   = CW'(BORDER);
    localparam logic [CW-1:0] Y_HI   = CW'(IMG_H - 1 - BORDER);
    localparam logic [CW-1:0] E_MINX = CW'(IMG_W);
    localparam logic [CW-1:0] E_MINY = CW'(IMG_H);
    localparam logic [SW-1:0] STEP_LAST = SW'(ACC_W - 1);

    typedef enum logic [1:0] {ACC, DIVX, DIVY, DONE} state_t;
    state_t state, state_nxt;

    logic             unused_hsync;
    logic             vsync_q, eof, accept, drop, qual, a_big, s_big, last;
    logic [CW-1:0]    a_minx, a_maxx, a_miny, a_maxy;
    logic [CW-1:0]    s_minx, s_maxx, s_miny, s_maxy, qx;
    logic [ACC_W-1:0] a_sx, a_sy, s_sy, dq, dq_nx;
    logic [CNT_W-1:0] a_cnt, s_cnt;
    logic [CNT_W:0]   rem, rem_sh, rem_nx;
    logic [SW-1:0]    step;
    logic             ge;

    assign unused_hsync = bus.hsync;

    assign eof    = vsync_q & ~bus.vsync;
    assign accept = eof & (state == ACC || state == DONE);
    assign drop   = eof & (state == DIVX || state == DIVY);
    assign qual   = bus.de & bus.vsync & bus.mask &
                    (bus.c_w >= X_LO) & (bus.c_w <= X_HI) &
                    (bus.c_h >= Y_LO) & (bus.c_h <= Y_HI);
    assign a_big  = a_cnt >= CNT_W'(MIN_PIX);
    assign s_big  = s_cnt >= CNT_W'(MIN_PIX);
    assign last   = step == STEP_LAST;

    // One restoring-division step: dq shifts the dividend out and the
    // quotient bits in, so after ACC_W steps dq holds the quotient.
    always_comb begin
        rem_sh = {rem[CNT_W-1:0], dq[ACC_W-1]};
        ge     = rem_sh >= {1'b0, s_cnt};
        rem_nx = ge ? rem_sh - {1'b0, s_cnt} : rem_sh;
        dq_nx  = {dq[ACC_W-2:0], ge};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:  if (eof) state_nxt = a_big ? DIVX : DONE;
            DIVX: if (last) state_nxt = DIVY;
            DIVY: if (last) state_nxt = DONE;
            DONE: state_nxt = eof ? (a_big ? DIVX : DONE) : ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         state <= ACC;
        else if (bus.ce) state <= state_nxt;
    end

    // Stream counters and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            bus.c_w <= '0;  bus.c_h <= '0;
            a_minx  <= E_MINX; a_maxx <= '0; a_miny <= E_MINY; a_maxy <= '0;
            a_sx    <= '0;  a_sy <= '0;  a_cnt <= '0;
            s_minx  <= '0;  s_maxx <= '0; s_miny <= '0; s_maxy <= '0;
            s_sy    <= '0;  s_cnt <= '0;
        end else if (bus.ce) begin
            vsync_q <= bus.vsync;
            if (!bus.vsync) begin
                bus.c_w <= '0;
                bus.c_h <= '0;
            end else if (bus.de) begin
                if (bus.c_w == W_LAST) begin
                    bus.c_w <= '0;
                    bus.c_h <= (bus.c_h == H_LAST) ? '0 : bus.c_h + CW'(1);
                end else begin
                    bus.c_w <= bus.c_w + CW'(1);
                end
            end
            // vsync is low on the eof cycle, so no pixel can qualify then.
            if (eof) begin
                if (accept) begin
                    s_minx <= a_minx; s_maxx <= a_maxx;
                    s_miny <= a_miny; s_maxy <= a_maxy;
                    s_sy   <= a_sy;   s_cnt  <= a_cnt;
                end
                a_minx <= E_MINX; a_maxx <= '0; a_miny <= E_MINY; a_maxy <= '0;
                a_sx   <= '0;     a_sy   <= '0; a_cnt  <= '0;
            end else if (qual) begin
                if (bus.c_w < a_minx) a_minx <= bus.c_w;
                if (bus.c_w > a_maxx) a_maxx <= bus.c_w;
                if (bus.c_h < a_miny) a_miny <= bus.c_h;
                if (bus.c_h > a_maxy) a_maxy <= bus.c_h;
                a_sx  <= a_sx + ACC_W'(bus.c_w);
                a_sy  <= a_sy + ACC_W'(bus.c_h);
                a_cnt <= a_cnt + CNT_W'(1);
            end
        end
    end

    // Shared divider: sum_x is loaded straight from the live accumulator at
    // eof (the snapshot register is written in the same edge); sum_y follows
    // from the snapshot once the x quotient is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            dq <= '0; rem <= '0; step <= '0; qx <= '0;
        end else if (bus.ce) begin
            if (accept && a_big) begin
                dq   <= a_sx;
                rem  <= '0;
                step <= '0;
            end else if (state == DIVX || state == DIVY) begin
                dq   <= dq_nx;
                rem  <= rem_nx;
                step <= last ? '0 : step + SW'(1);
                if (state == DIVX && last) begin
                    qx  <= dq_nx[CW-1:0];
                    dq  <= s_sy;
                    rem <= '0;
                end
            end
        end
    end

    // Result registers. Strobes drop after one clock even while ce is low so
    // they never stretch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.x_min <= '0; bus.x_max <= '0; bus.y_min <= '0; bus.y_max <= '0;
            bus.cx <= '0; bus.cy <= '0; bus.pix_cnt <= '0;
            bus.box_valid <= 1'b0; bus.res_valid <= 1'b0; bus.frame_drop <= 1'b0;
        end else begin
            bus.res_valid  <= 1'b0;
            bus.frame_drop <= 1'b0;
            if (bus.ce) begin
                bus.frame_drop <= drop;
                if (state == DONE) begin
                    bus.x_min     <= s_minx;
                    bus.x_max     <= s_maxx;
                    bus.y_min     <= s_miny;
                    bus.y_max     <= s_maxy;
                    bus.pix_cnt   <= s_cnt;
                    bus.box_valid <= s_big;
                    bus.cx        <= s_big ? qx : '0;
                    bus.cy        <= s_big ? dq[CW-1:0] : '0;
                    bus.res_valid <= 1'b1;
                end
            end
        end
    end
endmodule
